stream_fifo: RTL
================

// Module: stream_fifo
// PURPOSE
//  Elastic valid/ready buffer that sits between the master's data_out/valid/ready port
//    and the salve's data_in_s input.
//  Absorbs downstream stalls, including salve busy back-pressure, without dropping beats.
//  Decouples the ready path so upstream ready never depends combinationally on downstream ready.
//  First-word-fall-through; sustains 1 beat/cycle when neither side stalls.
// PARAMETERS
//  DATA_W  8  beat width in bits
//  DEPTH   4  entries; power of two, >= 2
//  AW      $clog2(DEPTH)  pointer width; derived, not overridden
// PORTS
//  clk      in   1       single clock; everything on rising edge
//  rst      in   1       reset: synchronous, active-high
//  s_valid  in   1       upstream beat valid (from master valid)
//  s_data   in   DATA_W  upstream beat (from master data_out)
//  s_ready  out  1       buffer can accept; registered
//  m_valid  out  1       downstream beat valid (to salve valid); registered
//  m_data   out  DATA_W  downstream beat (to salve data_in_s); registered
//  m_ready  in   1       downstream accepts (from salve ready)
// BEHAVIOUR
//  Reset, rst=1 at an edge: s_ready=0, m_valid=0, m_data=0, pointers=0, count=0, state=EMPTY.
//    s_ready rises on the first edge with rst=0.
//  Rst asserted mid-operation: all stored beats are discarded; no beat is presented after reset.
//  Transfers: push = s_valid & s_ready; pop = m_valid & m_ready.
//    A beat is consumed only on the handshake.
//  While m_valid=1 and m_ready=0, m_valid and m_data must hold stable.
//  Latency: a beat pushed into an EMPTY buffer at edge N appears on m_valid/m_data
//    after edge N, so it is visible in cycle N+1. It can pop in that same cycle.
//  State machine, encoded in pkg, from next count:
//    EMPTY (count=0) --push--> PARTIAL.
//    PARTIAL --push & !pop & count=DEPTH-1--> FULL.
//    PARTIAL --pop & !push & count=1--> EMPTY.
//    FULL --pop--> PARTIAL.
//    Every other combination stays in the current state.
//  s_ready = (next_state != FULL). m_valid = (next_state != EMPTY).
//    Both are registered from the next state.
//  Simultaneous push and pop in PARTIAL: count is unchanged and both pointers advance.
//  FULL: s_ready=0, so no push can occur; a pop re-opens s_ready on the next cycle.
//  EMPTY: no pop can occur. A push with no pop makes m_valid=1 next cycle.
//  Pointers are AW bits and wrap DEPTH-1 -> 0 naturally. count is AW+1 bits, range 0..DEPTH.
//  m_data is the registered head entry. On a pop it loads the next entry in the same edge,
//    including a beat pushed that edge when count=1.
//  Any push while !s_ready and any pop while !m_valid are ignored and leave state unchanged.
// CONFIGURATION
//  STREAM_FIFO_LEVEL_EN defined:
//    adds output port level [AW:0]; registered occupancy equal to count; resets to 0.
//  Undefined: the level port does not exist. Behaviour is otherwise identical.
// STRUCTURE
//  stream_fifo_pkg holds:
//    state typedef {EMPTY, PARTIAL, FULL}
//    DATA_W default constant
//  Sub-module stream_fifo_mem: DEPTH x DATA_W register array.
//    Single write port (we, waddr, wdata) and async read port (raddr -> rdata).
//    It has no reset.
//  Top keeps pointers, count, state, and the output registers.
// TESTING
//  1. Reset: hold rst=1 for 3 cycles with s_valid=1.
//     -> s_ready=0, m_valid=0, m_data=0; s_ready=1 the cycle after rst falls.
//  2. Stream 0x00..0x0F with m_ready=1 constantly.
//     -> one output per cycle, in order, first one cycle after the first push, no bubbles.
//  3. m_ready=0 while pushing 0x10..0x15.
//     -> 4 accepted, s_ready=0 after the 4th, m_data held at 0x10.
//     -> release m_ready: out 0x10..0x13, then 0x14, 0x15.
//  4. Fill to count=2, then drive s_valid and m_ready together for 8 cycles.
//     -> count stays 2, pointers wrap twice, order preserved.
//  5. Push 0xA5, 0x5A; assert rst for 1 cycle before the pops.
//     -> m_valid=0 after reset; neither beat ever appears on m_data.
//  6. With STREAM_FIFO_LEVEL_EN, repeat 3.
//     -> level steps 0,1,2,3,4, holds at 4, then counts down to 0.

Source files
------------

// File: rtl/stream_fifo_pkg.sv
// Shared types and defaults for the stream_fifo elastic buffer.
package stream_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_DEPTH  = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port, no reset.
module stream_fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AW     = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO with fully registered handshake outputs.
// Optional STREAM_FIFO_LEVEL_EN adds a registered occupancy port "level".
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int unsigned  DATA_W = DEFAULT_DATA_W,
  parameter int unsigned  DEPTH  = DEFAULT_DEPTH,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
`ifdef STREAM_FIFO_LEVEL_EN
  output logic [AW:0]       level,
`endif
  input  logic              m_ready
);

  logic              push;
  logic              pop;
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW-1:0]     rptr_nxt;
  logic [AW:0]       count;
  logic [AW:0]       count_nxt;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] head_nxt;
  state_t            state;
  state_t            state_nxt;

  stream_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (s_data),
    .raddr (rptr_nxt),
    .rdata (rdata)
  );

  // Handshakes, next pointers/count and the next head entry.
  always_comb begin
    push      = s_valid & s_ready;
    pop       = m_valid & m_ready;
    rptr_nxt  = rptr + AW'(pop);
    count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
    head_nxt  = m_data;
    // A beat pushed into an otherwise-empty buffer bypasses storage to the head.
    if (push && (count == (AW+1)'(pop))) begin
      head_nxt = s_data;
    end else if (pop && (count > (AW+1)'(1))) begin
      head_nxt = rdata;
    end
  end

  // Occupancy state transitions.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (push) state_nxt = PARTIAL;
      end
      PARTIAL: begin
        if (push && !pop && (count == (AW+1)'(DEPTH - 1))) begin
          state_nxt = FULL;
        end else if (pop && !push && (count == (AW+1)'(1))) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) state_nxt = PARTIAL;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      state   <= EMPTY;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      wptr    <= wptr + AW'(push);
      rptr    <= rptr_nxt;
      count   <= count_nxt;
      state   <= state_nxt;
      s_ready <= (state_nxt != FULL);
      m_valid <= (state_nxt != EMPTY);
      m_data  <= head_nxt;
    end
  end

`ifdef STREAM_FIFO_LEVEL_EN
  assign level = count;
`endif

endmodule
